// File: rtl/rst_seq_sync_pkg.sv
// Shared definitions for the reset synchroniser / sequencer.
//  - state_t   : sequencer FSM states
//  - MIN_*     : lowest legal values of the block parameters
//  - max_int() : elaboration-time helper for sizing the cycle counter
package rst_seq_sync_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    HOLD      = 2'd1,
    STEP      = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int MIN_STAGES = 2;
  localparam int MIN_OUTS   = 1;
  localparam int MIN_HOLD   = 1;
  localparam int MIN_STEP   = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync_chain.sv
// De-assert synchroniser for the board reset.
// RST clears every stage asynchronously; a 1 is shifted in from stage 0 on
// each CLK rising edge, so sync_ok rises after edge NUM_STAGES.
// Ports:
//  CLK     in   clock
//  RST     in   asynchronous active-high reset
//  sync_ok out  1 once the release has propagated through all stages
module rst_seq_sync_chain
  import rst_seq_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_ok
);

  if (NUM_STAGES < MIN_STAGES) begin : g_chk_stages
    $error("rst_seq_sync_chain: NUM_STAGES must be >= %0d", MIN_STAGES);
  end

  logic [NUM_STAGES-1:0] chain_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchroniser and sequencer.
// Asserts all downstream resets asynchronously on RST, waits for the
// synchronised release, holds for HOLD_CYCLES, then releases SYNC_RST bits
// in index order every STEP_CYCLES. SW_RST_REQ restarts the hold/step
// sequence without touching the synchroniser.
// Ports:
//  CLK         in   clock
//  RST         in   asynchronous active-high reset
//  SW_RST_REQ  in   synchronous software reset request
//  SYNC_RST    out  NUM_OUTS sequenced resets, bit 0 released first
//                   (active-low when OUT_ACT_LOW=1)
//  RST_DONE    out  1 when every domain has been released
module rst_seq_sync
  import rst_seq_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STEP_CYCLES = 2,
  parameter int OUT_ACT_LOW = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic [NUM_OUTS-1:0] SYNC_RST,
  output logic                RST_DONE
);

  if (NUM_OUTS < MIN_OUTS) begin : g_chk_outs
    $error("rst_seq_sync: NUM_OUTS must be >= %0d", MIN_OUTS);
  end
  if (HOLD_CYCLES < MIN_HOLD) begin : g_chk_hold
    $error("rst_seq_sync: HOLD_CYCLES must be >= %0d", MIN_HOLD);
  end
  if (STEP_CYCLES < MIN_STEP) begin : g_chk_step
    $error("rst_seq_sync: STEP_CYCLES must be >= %0d", MIN_STEP);
  end

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STEP_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_OUTS) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(max_int(HOLD_CYCLES, STEP_CYCLES));
  localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_OUTS);
  localparam logic             ASSERT_LVL = (OUT_ACT_LOW != 0) ? 1'b0 : 1'b1;

  logic                sync_ok;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]    idx_q, idx_d, rel_idx;
  logic [NUM_OUTS-1:0] sync_q, sync_d;
  logic                done_q, done_d;
  logic                rel_en, clr_all;

  rst_seq_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_chain (
    .CLK     (CLK),
    .RST     (RST),
    .sync_ok (sync_ok)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= WAIT_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      sync_q  <= {NUM_OUTS{ASSERT_LVL}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;
    rel_en  = 1'b0;
    rel_idx = '0;
    clr_all = 1'b0;
    sync_d  = sync_q;
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      WAIT_SYNC: begin
        // The edge that first sees sync_ok already counts as hold cycle 1,
        // which puts release 0 at edge NUM_STAGES + HOLD_CYCLES.
        if (sync_ok) begin
          if (HOLD_LAST == '0) begin
            rel_en  = 1'b1;
            rel_idx = '0;
            state_d = STEP;
            cnt_d   = '0;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rel_en  = 1'b1;
          rel_idx = '0;
          state_d = STEP;
          cnt_d   = '0;
          idx_d   = IDX_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STEP: begin
        // idx_q == NUM_OUTS means the last bit went out on the previous edge.
        if (idx_q == IDX_END) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cnt_q == STEP_LAST) begin
          rel_en  = 1'b1;
          rel_idx = idx_q;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase

    // Software request overrides any release scheduled for this edge.
    if (SW_RST_REQ && (state_q != WAIT_SYNC)) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
      rel_en  = 1'b0;
      clr_all = 1'b1;
    end

    for (int i = 0; i < NUM_OUTS; i++) begin
      if (clr_all) begin
        sync_d[i] = ASSERT_LVL;
      end else if (rel_en && (rel_idx == IDX_W'(i))) begin
        sync_d[i] = ~ASSERT_LVL;
      end
    end
  end

  assign SYNC_RST = sync_q;
  assign RST_DONE = done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
module tb_rst_seq_sync;

  localparam int NA = 2, OA = 3, HA = 4, SA = 2;
  localparam int NB = 3, OB = 1, HB = 1, SB = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SW_RST_REQ;
  logic [OA-1:0] sync_a;
  logic          done_a;
  logic [OB-1:0] sync_b;
  logic          done_b;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Reference model: edges since RST fell, and the edge that anchors the
  // hold window (NUM_STAGES after reset, or the last accepted SW request).
  int edge_n = 0;
  int base_a = NA;
  int base_b = NB;

  always #5 CLK = ~CLK;

  rst_seq_sync #(
    .NUM_STAGES (NA), .NUM_OUTS (OA), .HOLD_CYCLES (HA),
    .STEP_CYCLES (SA), .OUT_ACT_LOW (1)
  ) dut_a (
    .CLK (CLK), .RST (RST), .SW_RST_REQ (SW_RST_REQ),
    .SYNC_RST (sync_a), .RST_DONE (done_a)
  );

  rst_seq_sync #(
    .NUM_STAGES (NB), .NUM_OUTS (OB), .HOLD_CYCLES (HB),
    .STEP_CYCLES (SB), .OUT_ACT_LOW (0)
  ) dut_b (
    .CLK (CLK), .RST (RST), .SW_RST_REQ (SW_RST_REQ),
    .SYNC_RST (sync_b), .RST_DONE (done_b)
  );

  // A request is honoured once the sequencer has left WAIT_SYNC, i.e. from
  // edge NUM_STAGES+2 on (sync_ok appears after edge NUM_STAGES and is acted
  // on at the following edge).
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_n <= 0;
      base_a <= NA;
      base_b <= NB;
    end else begin
      edge_n <= edge_n + 1;
      if (SW_RST_REQ && (edge_n + 1 >= NA + 2)) base_a <= edge_n + 1;
      if (SW_RST_REQ && (edge_n + 1 >= NB + 2)) base_b <= edge_n + 1;
    end
  end

  function automatic logic [31:0] rel_mask(input int e, input int base,
                                           input int o, input int h, input int s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < o; i++) begin
      if (e >= base + h + i * s) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic done_exp(input int e, input int base,
                                    input int o, input int h, input int s);
    return (e >= base + h + (o - 1) * s + 1);
  endfunction

  // Directed expectations: edges since RST release
  function automatic logic [2:0] seq_a(input int e);
    if (e < 6) return 3'b000;
    if (e < 8) return 3'b001;
    if (e < 10) return 3'b011;
    return 3'b111;
  endfunction

  // Directed expectations: edges since last SW request edge
  function automatic logic [2:0] sw_a(input int j);
    if (j < 4) return 3'b000;
    if (j < 6) return 3'b001;
    if (j < 8) return 3'b011;
    return 3'b111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    assert (act === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ma, mb;
    ma = rel_mask(edge_n, base_a, OA, HA, SA);
    mb = rel_mask(edge_n, base_b, OB, HB, SB);
    chk($sformatf("%s model sync_a e%0d", tag, edge_n), 32'(sync_a), ma);
    chk($sformatf("%s model done_a e%0d", tag, edge_n), 32'(done_a),
        32'(done_exp(edge_n, base_a, OA, HA, SA)));
    chk($sformatf("%s model sync_b e%0d", tag, edge_n), 32'(sync_b),
        ~mb & ((32'd1 << OB) - 32'd1));
    chk($sformatf("%s model done_b e%0d", tag, edge_n), 32'(done_b),
        32'(done_exp(edge_n, base_b, OB, HB, SB)));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_in_reset(input string tag);
    chk({tag, " sync_a"}, 32'(sync_a), 32'h0);
    chk({tag, " done_a"}, 32'(done_a), 32'h0);
    chk({tag, " sync_b"}, 32'(sync_b), 32'h1);
    chk({tag, " done_b"}, 32'(done_b), 32'h0);
    check_model(tag);
  endtask

  task automatic run_seq(input int n, input string tag);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk($sformatf("%s sync_a e%0d", tag, e), 32'(sync_a), 32'(seq_a(e)));
      chk($sformatf("%s done_a e%0d", tag, e), 32'(done_a), 32'(e >= 11));
      chk($sformatf("%s sync_b e%0d", tag, e), 32'(sync_b), 32'(e < 4));
      chk($sformatf("%s done_b e%0d", tag, e), 32'(done_b), 32'(e >= 5));
      check_model(tag);
    end
  endtask

  task automatic chk_sw(input int j, input string tag);
    chk($sformatf("%s sync_a j%0d", tag, j), 32'(sync_a), 32'(sw_a(j)));
    chk($sformatf("%s done_a j%0d", tag, j), 32'(done_a), 32'(j >= 9));
    chk($sformatf("%s sync_b j%0d", tag, j), 32'(sync_b), 32'(j < 1));
    chk($sformatf("%s done_b j%0d", tag, j), 32'(done_b), 32'(j >= 2));
    check_model(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    RST = 1'b0;
    SW_RST_REQ = 1'b0;
    #2 RST = 1'b1;
    #1 chk_in_reset("por_async");
    tick();
    tick();
    chk_in_reset("reset_held");

    // Release between edges; default and small configs run in parallel
    #3 RST = 1'b0;
    run_seq(12, "seq1");

    // 3 ns reset pulse mid-cycle while in DONE
    #2 RST = 1'b1;
    #3 RST = 1'b0;
    #1 chk_in_reset("short_pulse");
    run_seq(12, "seq2");

    // One-cycle software request in DONE
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    chk_sw(0, "sw_pulse");
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk_sw(j, "sw_pulse");
    end

    // Software request held for 10 edges while in STEP
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    repeat (5) tick();
    chk("pre_held sync_a", 32'(sync_a), 32'h1);
    SW_RST_REQ = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("sw_held sync_a c%0d", j), 32'(sync_a), 32'h0);
      chk($sformatf("sw_held done_a c%0d", j), 32'(done_a), 32'h0);
      chk($sformatf("sw_held sync_b c%0d", j), 32'(sync_b), 32'h1);
      check_model("sw_held");
    end
    SW_RST_REQ = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk_sw(j, "sw_after_held");
    end

    // Reset re-asserted after edge 7 of a fresh sequence
    RST = 1'b1;
    tick();
    #3 RST = 1'b0;
    run_seq(7, "seq3");
    #2 RST = 1'b1;
    #1 chk_in_reset("mid_rst");
    #2 RST = 1'b0;
    run_seq(12, "seq4");

    // Random software requests and short reset pulses against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        d = $urandom_range(1, 3);
        #(d);
        RST = 1'b1;
        #1 chk_in_reset("rand_rst");
        d = $urandom_range(1, 3);
        #(d);
        RST = 1'b0;
      end
      SW_RST_REQ = ($urandom_range(0, 24) == 0);
      tick();
      check_model("rand");
    end
    SW_RST_REQ = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
